// File: rtl/elevator_ctrl_if.sv
// Call/position bundle between the elevator controller and its panel.
// The controller side is slave; the panel side (buttons, arrow decoder) is master.
interface elevator_ctrl_if #(
    parameter int N_FLOORS = 8,
    parameter int FW       = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1
);
    logic [N_FLOORS-1:0] req;
    logic [FW-1:0]       floor;
    logic                stop;
    logic                head;
    logic                door_open;
    logic [N_FLOORS-1:0] pending;

    modport master (
        output req,
        input  floor, stop, head, door_open, pending
    );

    modport slave (
        input  req,
        output floor, stop, head, door_open, pending
    );
endinterface

// File: rtl/elevator_ctrl.sv
// SCAN elevator controller: latches calls, times travel and door,
// and drives the stop/head pair for the direction-arrow decoder.
module elevator_ctrl #(
    parameter int N_FLOORS    = 8,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 6
) (
    input logic           clk,
    input logic           rst,
    elevator_ctrl_if.slave bus
);
    localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
    localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DOOR
    } state_t;

    state_t              state_q, state_d;
    logic [FW-1:0]       floor_q, floor_d;
    logic                head_q, head_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [MW-1:0]       mtmr_q, mtmr_d;
    logic [DW-1:0]       dtmr_q, dtmr_d;

    logic                eval;
    logic [FW-1:0]       eval_f;
    logic                up_any;
    logic                dn_any;

    function automatic logic [1:0] dir_calls(
        input logic [N_FLOORS-1:0] p,
        input logic [FW-1:0]       f
    );
        logic up, dn;
        up = 1'b0;
        dn = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (p[i] && (i > int'(f))) up = 1'b1;
            if (p[i] && (i < int'(f))) dn = 1'b1;
        end
        return {up, dn};
    endfunction

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        head_d    = head_q;
        mtmr_d    = mtmr_q;
        dtmr_d    = dtmr_q;
        pending_d = pending_q | bus.req;
        eval      = 1'b0;
        eval_f    = floor_q;

        unique case (state_q)
            S_IDLE: eval = 1'b1;
            S_MOVE: begin
                if (mtmr_q == MW'(MOVE_CYCLES - 1)) begin
                    eval    = 1'b1;
                    floor_d = head_q ? floor_q + FW'(1) : floor_q - FW'(1);
                    eval_f  = floor_d;
                end else begin
                    mtmr_d = mtmr_q + MW'(1);
                end
            end
            S_DOOR: begin
                // Calls at the open floor are dropped, not queued.
                pending_d[floor_q] = 1'b0;
                if (dtmr_q == DW'(DOOR_CYCLES - 1)) eval = 1'b1;
                else dtmr_d = dtmr_q + DW'(1);
            end
            default: ;
        endcase

        {up_any, dn_any} = dir_calls(pending_d, eval_f);

        if (eval) begin
            if (pending_d[eval_f]) begin
                state_d           = S_DOOR;
                pending_d[eval_f] = 1'b0;
                dtmr_d            = '0;
            end else if (head_q ? up_any : dn_any) begin
                state_d = S_MOVE;
                mtmr_d  = '0;
            end else if (head_q ? dn_any : up_any) begin
                state_d = S_MOVE;
                head_d  = ~head_q;
                mtmr_d  = '0;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            floor_q   <= '0;
            head_q    <= 1'b1;
            pending_q <= '0;
            mtmr_q    <= '0;
            dtmr_q    <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            head_q    <= head_d;
            pending_q <= pending_d;
            mtmr_q    <= mtmr_d;
            dtmr_q    <= dtmr_d;
        end
    end

    assign bus.floor     = floor_q;
    assign bus.stop      = (state_q != S_MOVE);
    assign bus.head      = head_q;
    assign bus.door_open = (state_q == S_DOOR);
    assign bus.pending   = pending_q;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed scenarios plus random calls,
// every cycle compared against a countdown-based behavioural model.
module tb_elevator_ctrl;
    localparam int NF = 8;
    localparam int MC = 4;
    localparam int DC = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    elevator_ctrl_if #(.N_FLOORS(NF)) bus ();

    elevator_ctrl #(
        .N_FLOORS(NF),
        .MOVE_CYCLES(MC),
        .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int         m_floor;
    bit         m_head;
    bit [7:0]   m_pend;
    bit         m_moving;
    int         m_door_left;
    int         m_move_left;

    task automatic model(input logic [7:0] r, input logic rs);
        int p;
        bit ev;
        bit up, dn;
        if (rs) begin
            m_floor = 0; m_head = 1; m_pend = 0;
            m_moving = 0; m_door_left = 0; m_move_left = 0;
            return;
        end
        p = int'(m_pend | r);
        ev = 0;
        if (m_door_left > 0) begin
            p = p & ~(1 << m_floor);
            m_door_left--;
            ev = (m_door_left == 0);
        end else if (m_moving) begin
            m_move_left--;
            if (m_move_left == 0) begin
                m_floor = m_head ? m_floor + 1 : m_floor - 1;
                m_moving = 0;
                ev = 1;
            end
        end else begin
            ev = 1;
        end
        if (ev) begin
            up = (p >> (m_floor + 1)) != 0;
            dn = (p & ((1 << m_floor) - 1)) != 0;
            m_moving = 0;
            if (p[m_floor]) begin
                p = p & ~(1 << m_floor);
                m_door_left = DC;
            end else if (m_head ? up : dn) begin
                m_moving = 1; m_move_left = MC;
            end else if (m_head ? dn : up) begin
                m_head = !m_head;
                m_moving = 1; m_move_left = MC;
            end
        end
        m_pend = p[7:0];
    endtask

    task automatic compare();
        bit ok;
        checks++;
        ok = (int'(bus.floor) == m_floor) && (bus.head == m_head) &&
             (bus.stop == !m_moving) && (bus.door_open == (m_door_left > 0)) &&
             (bus.pending == m_pend);
        if (!ok) begin
            failures++;
            $display("FAIL model cyc=%0d floor=%0d/%0d head=%0b/%0b stop=%0b/%0b door=%0b/%0b pend=%h/%h",
                     cyc, bus.floor, m_floor, bus.head, m_head, bus.stop, !m_moving,
                     bus.door_open, (m_door_left > 0), bus.pending, m_pend);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic rs);
        bus.req = r;
        rst = rs;
        @(posedge clk);
        model(r, rs);
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0);
    endtask

    int door_cnt;

    initial begin
        rst = 1'b1;
        bus.req = '0;
        model(8'h00, 1'b1);
        @(negedge clk);
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        chk("rst_floor", int'(bus.floor), 0);
        chk("rst_stop", int'(bus.stop), 1);
        chk("rst_head", int'(bus.head), 1);
        chk("rst_door", int'(bus.door_open), 0);
        chk("rst_pend", int'(bus.pending), 0);
        idle_steps(20);
        chk("idle_floor", int'(bus.floor), 0);

        // Call at the current floor: door for exactly DC cycles
        step(8'h01, 1'b0);
        chk("f0_door", int'(bus.door_open), 1);
        chk("f0_pend", int'(bus.pending), 0);
        door_cnt = 1;
        for (int i = 0; i < 10; i++) begin
            step(8'h00, 1'b0);
            if (bus.door_open) door_cnt++;
        end
        chk("f0_door_len", door_cnt, 6);

        // Single trip 0 -> 3
        step(8'h08, 1'b0);
        chk("up_stop", int'(bus.stop), 0);
        chk("up_head", int'(bus.head), 1);
        idle_steps(4);
        chk("up_f1", int'(bus.floor), 1);
        idle_steps(8);
        chk("up_f3", int'(bus.floor), 3);
        chk("up_door", int'(bus.door_open), 1);
        chk("up_pend", int'(bus.pending), 0);
        idle_steps(6);
        chk("up_idle", int'(bus.stop), 1);
        chk("up_closed", int'(bus.door_open), 0);

        // SCAN: calls at 0 and 6 from floor 3 heading up
        step(8'h41, 1'b0);
        chk("scan_stop0", int'(bus.stop), 0);
        chk("scan_head0", int'(bus.head), 1);
        idle_steps(12);
        chk("scan_f6", int'(bus.floor), 6);
        chk("scan_door6", int'(bus.door_open), 1);
        idle_steps(6);
        chk("scan_rev_stop", int'(bus.stop), 0);
        chk("scan_rev_head", int'(bus.head), 0);
        idle_steps(24);
        chk("scan_f0", int'(bus.floor), 0);
        chk("scan_door0", int'(bus.door_open), 1);
        idle_steps(6);

        // Passing-floor pickup at 2 on the way to 5
        step(8'h20, 1'b0);
        idle_steps(7);
        step(8'h04, 1'b0);
        chk("pass_f2", int'(bus.floor), 2);
        chk("pass_door", int'(bus.door_open), 1);
        idle_steps(6);
        chk("pass_resume", int'(bus.stop), 0);
        idle_steps(12);
        chk("pass_f5", int'(bus.floor), 5);
        chk("pass_door5", int'(bus.door_open), 1);
        idle_steps(6);

        // Reset mid-MOVE at floor 4
        step(8'h01, 1'b0);
        idle_steps(5);
        chk("mr_f4", int'(bus.floor), 4);
        chk("mr_moving", int'(bus.stop), 0);
        step(8'h00, 1'b1);
        chk("mr_floor", int'(bus.floor), 0);
        chk("mr_stop", int'(bus.stop), 1);
        chk("mr_head", int'(bus.head), 1);
        chk("mr_pend", int'(bus.pending), 0);

        // Reset mid-DOOR
        step(8'h01, 1'b0);
        step(8'h80, 1'b0);
        chk("dr_door", int'(bus.door_open), 1);
        step(8'h00, 1'b1);
        chk("dr_door_off", int'(bus.door_open), 0);
        chk("dr_pend", int'(bus.pending), 0);
        chk("dr_stop", int'(bus.stop), 1);

        // Random calls with rare resets
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] r;
            int x;
            r = 8'h00;
            x = int'($urandom_range(0, 11));
            if (x == 0) r = 8'(1 << $urandom_range(0, 7));
            else if (x == 1) r = 8'($urandom);
            step(r, ($urandom_range(0, 499) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
